// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_pkg                                                         |
// | Purpose  : Shared constants for the SPI command front end: FSM state       |
// |            encoding, command opcodes and default word/data widths.         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package spi_pkg;

    // Default widths: 2-bit opcode + 8-bit payload, 8-bit read data
    localparam int SPI_WORD_W = 10;
    localparam int SPI_DATA_W = 8;

    // Slave FSM state encoding
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] CHK_CMD   = 3'd1;
    localparam logic [STATE_W-1:0] WRITE     = 3'd2;
    localparam logic [STATE_W-1:0] READ_ADD  = 3'd3;
    localparam logic [STATE_W-1:0] READ_DATA = 3'd4;

    // Command opcodes carried in word bits [9:8]
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_piso.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_piso                                                        |
// | Purpose  : Parallel-load, serial-out shifter for MISO read data, MSB first.|
// | Ports    : clk, rst_n   - clock, synchronous active-low reset              |
// |            clear        - drop any byte in flight (frame ended)            |
// |            load, data   - capture a new byte; bit MSB shows next cycle     |
// |            shift_en     - advance one bit per cycle while a byte is held   |
// |            serial       - current output bit, 0 when nothing to send       |
// |            busy         - bits remain to be presented                      |
// |            done         - sticky: the whole byte has been presented        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] data,
    output logic              serial,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_left;   // bits still to be presented, including current
    logic              r_done;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_shift <= '0;
            r_left  <= '0;
            r_done  <= 1'b0;
        end else if (load) begin
            r_shift <= data;
            r_left  <= CNT_W'(DATA_W);
            r_done  <= 1'b0;
        end else if (shift_en && (r_left != '0)) begin
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            r_left  <= r_left - CNT_W'(1);
            if (r_left == CNT_W'(1)) begin
                r_done <= 1'b1;
            end
        end
    end

    // Output is forced low whenever no byte is in flight
    assign busy   = (r_left != '0);
    assign serial = busy ? r_shift[DATA_W-1] : 1'b0;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_slave                                                       |
// | Purpose  : SPI front end for the command RAM. Deserialises one command     |
// |            word per ss_n frame, strobes it out, and for read-data commands |
// |            returns the RAM's byte on MISO, MSB first. SCK == clk.          |
// | Ports    : clk, rst_n         - clock, synchronous active-low reset        |
// |            ss_n, mosi         - slave select (active low), serial data in  |
// |            miso               - serial data out                            |
// |            rx_data, rx_valid  - command word and its one-cycle strobe      |
// |            tx_data, tx_valid  - read byte from RAM and its strobe          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_slave
    import spi_pkg::*;
#(
    parameter int WORD_W = SPI_WORD_W,
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int               CNT_W      = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] c_WORD_LEN = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WORD_W - 1);

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;          // bits accepted this frame, saturates at WORD_W
    logic [WORD_W-2:0]  r_shift;        // all but the final bit of the word
    logic [WORD_W-1:0]  r_rx_data;
    logic               r_rx_valid;
    logic               r_rd_addr_seen; // a read address is pending its read-data command

    logic w_word_done;
    logic w_tx_load;
    logic w_tx_shift_en;
    logic w_piso_busy;
    logic w_piso_done;

    assign w_word_done = (r_cnt == c_WORD_LEN);

    // Only the first response after a complete read-data word is taken;
    // busy/done guard against later strobes in the same frame.
    assign w_tx_load = !ss_n && (r_state == READ_DATA) && w_word_done &&
                       tx_valid && !w_piso_busy && !w_piso_done;

    assign w_tx_shift_en = (r_state == READ_DATA);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_seen <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (ss_n) begin
                // Frame ended (or never started): abandon any partial word
                r_state <= IDLE;
                r_cnt   <= '0;
                r_shift <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        // First bit is opcode MSB: 0 = write, 1 = read
                        r_shift <= {{(WORD_W-2){1'b0}}, mosi};
                        r_cnt   <= CNT_W'(1);
                        if (!mosi) begin
                            r_state <= WRITE;
                        end else if (r_rd_addr_seen) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (r_cnt < c_WORD_LEN) begin
                            r_shift <= {r_shift[WORD_W-3:0], mosi};
                            r_cnt   <= r_cnt + CNT_W'(1);
                            if (r_cnt == c_LAST_BIT) begin
                                r_rx_data  <= {r_shift, mosi};
                                r_rx_valid <= 1'b1;
                                if (r_state == READ_ADD) begin
                                    r_rd_addr_seen <= 1'b1;
                                end else if (r_state == READ_DATA) begin
                                    r_rd_addr_seen <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    spi_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (ss_n),
        .load     (w_tx_load),
        .shift_en (w_tx_shift_en),
        .data     (tx_data),
        .serial   (miso),
        .busy     (w_piso_busy),
        .done     (w_piso_done)
    );

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_slave                                                    |
// | Purpose  : Self-checking bench for spi_slave: directed frames followed by  |
// |            random frames, compared against a frame-level reference model.  |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_spi_slave;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    always #5 clk = ~clk;

    spi_slave #(
        .WORD_W (10),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: only frame-level facts from the command protocol
    bit         m_seen = 1'b0;   // a read-address word has completed, read-data not yet
    logic [9:0] m_last = '0;     // last word delivered

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock, then check the per-cycle outputs
    task automatic step(input bit exp_rxv, input bit exp_miso, input string tag);
        @(posedge clk);
        #1;
        chk({tag, " rx_valid"}, 32'(rx_valid), 32'(exp_rxv));
        chk({tag, " miso"}, 32'(miso), 32'(exp_miso));
    endtask

    // Idle cycles with stray RAM responses that must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ss_n     = 1'b1;
            mosi     = 1'($urandom);
            tx_valid = 1'($urandom);
            tx_data  = 8'hFF;
            step(1'b0, 1'b0, "idle");
        end
        tx_valid = 1'b0;
    endtask

    // One ss_n frame. nbits < 10 raises ss_n in place of bit 'nbits'.
    // extra = cycles ss_n stays low after the rx_valid cycle.
    // When send_tx is set the model RAM answers one cycle after rx_valid with b,
    // then strobes again with junk that must be ignored.
    task automatic frame(input logic [9:0] w, input int nbits, input int extra,
                         input bit send_tx, input logic [7:0] b, input string tag);
        bit full;
        bit rd_data;
        bit exp_m;
        full    = (nbits >= 10);
        rd_data = w[9] && m_seen;

        ss_n     = 1'b0;
        mosi     = 1'($urandom);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        step(1'b0, 1'b0, tag);

        for (int k = 0; k < nbits && k < 10; k++) begin
            mosi     = w[9-k];
            tx_valid = 1'($urandom);
            tx_data  = 8'hFF;
            step(k == 9, 1'b0, tag);
        end

        if (!full) begin
            ss_n     = 1'b1;
            mosi     = w[9-nbits];
            tx_valid = 1'b0;
            step(1'b0, 1'b0, {tag, " abort"});
            chk({tag, " rx_data held"}, 32'(rx_data), 32'(m_last));
            return;
        end

        chk({tag, " rx_data"}, 32'(rx_data), 32'(w));
        m_last = w;

        for (int j = 0; j < extra; j++) begin
            mosi     = 1'($urandom);
            tx_valid = send_tx && (j == 1 || j == 4);
            tx_data  = (j == 1) ? b : 8'($urandom);
            exp_m    = (rd_data && send_tx && j >= 1 && j <= 8) ? b[8-j] : 1'b0;
            step(1'b0, exp_m, {tag, " tail"});
        end
        tx_valid = 1'b0;

        ss_n = 1'b1;
        step(1'b0, 1'b0, {tag, " end"});
        chk({tag, " rx_data after"}, 32'(rx_data), 32'(w));

        if (w[9]) m_seen = !m_seen;
    endtask

    initial begin
        logic [9:0] rw;
        int         rn;

        // Reset held with an active-looking bus
        rst_n    = 1'b0;
        ss_n     = 1'b0;
        mosi     = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rx_data", 32'(rx_data), 32'h0);
        chk("reset rx_valid", 32'(rx_valid), 32'h0);
        chk("reset miso", 32'(miso), 32'h0);
        rst_n = 1'b1;
        idle(4);

        frame({OP_WR_ADDR, 8'hA5}, 10, 9, 1'b1, 8'hFF, "wr_addr");
        idle(2);
        frame({OP_WR_DATA, 8'h3C}, 10, 9, 1'b1, 8'hFF, "wr_data");
        idle(1);
        frame({OP_RD_ADDR, 8'h03}, 10, 10, 1'b1, 8'h55, "rd_addr");
        idle(2);
        frame({OP_RD_DATA, 8'h00}, 10, 10, 1'b1, 8'hC6, "rd_data");
        idle(2);
        frame(10'h2F0, 10, 10, 1'b1, 8'h81, "rd_addr2");
        idle(1);
        frame(10'h0AB, 6, 0, 1'b0, 8'h00, "abort6");
        idle(1);
        frame(10'h0FF, 10, 9, 1'b0, 8'h00, "wr_ff");
        idle(1);
        frame(10'h155, 9, 0, 1'b0, 8'h00, "abort9");
        idle(1);
        frame(10'h3A7, 10, 11, 1'b1, 8'h3B, "rd_data2");
        idle(2);

        for (int f = 0; f < 30; f++) begin
            rw = 10'($urandom);
            rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10;
            frame(rw, rn, int'($urandom_range(9, 12)), ($urandom_range(0, 3) != 0),
                  8'($urandom), "rand");
            idle(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
